iob_pcie_chnl_host: RTL and testbench

// - Host/channel end of the RIFFA-style PCIe channel: drives RX transactions into a user channel and sinks its TX replies.
// - Sends one host-to-user transfer of LEN 32-bit words from a 64-bit source stream.
// - Then accepts one user-to-host transfer and forwards it on a 64-bit sink stream.
// - Used as the channel-side engine in system simulation and as a loopback tester for iob_pcie user logic.

---
 rtl/iob_pcie_chnl_host.sv | 194 +++++++++++++++++++
 tb/tb_iob_pcie_chnl_host.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_pcie_chnl_host.sv
// Host/channel side of a RIFFA-style PCIe channel: one RX transfer from a source stream,
// then one TX transfer forwarded to a sink stream, with a handshake watchdog.
module iob_pcie_chnl_host #(
   parameter int C_PCI_DATA_WIDTH = 64,
   parameter int TIMEOUT_W        = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [31:0]                 len,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic [31:0]                 tx_len_rcvd,
   input  logic [C_PCI_DATA_WIDTH-1:0] src_data,
   input  logic                        src_valid,
   output logic                        src_ready,
   output logic [C_PCI_DATA_WIDTH-1:0] sink_data,
   output logic                        sink_valid,
   input  logic                        sink_ready,
   output logic                        CHNL_RX,
   input  logic                        CHNL_RX_ACK,
   output logic                        CHNL_RX_LAST,
   output logic [31:0]                 CHNL_RX_LEN,
   output logic [30:0]                 CHNL_RX_OFF,
   output logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
   output logic                        CHNL_RX_DATA_VALID,
   input  logic                        CHNL_RX_DATA_REN,
   input  logic                        CHNL_TX,
   output logic                        CHNL_TX_ACK,
   input  logic                        CHNL_TX_LAST,
   input  logic [31:0]                 CHNL_TX_LEN,
   input  logic [30:0]                 CHNL_TX_OFF,
   input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
   input  logic                        CHNL_TX_DATA_VALID,
   output logic                        CHNL_TX_DATA_REN
);

   typedef enum logic [2:0] {
      StIdle, StRxReq, StRxData, StTxWait, StTxAck, StTxData, StDone
   } state_e;

   // Last count value before saturation: firing here makes err rise 2**W-1 cycles in.
   localparam logic [TIMEOUT_W-1:0] TmoLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   state_e               state_q;
   logic [31:0]          len_q;
   logic [31:0]          tx_len_q;
   logic [32:0]          cnt_q;
   logic [TIMEOUT_W-1:0] tmo_q;
   logic                 busy_q, done_q, err_q, rx_q, tx_ack_q;

   logic [32:0] rx_beats, tx_beats;
   logic        rx_beat, tx_room, tx_ren, tx_beat, tmo_hit;
   logic        unused_inputs;

   assign rx_beats = ({1'b0, len_q} + 33'd1) >> 1;
   assign tx_beats = ({1'b0, tx_len_q} + 33'd1) >> 1;

   always_comb begin
      rx_beat = (state_q == StRxData) & src_valid & CHNL_RX_DATA_REN;
      tx_room = cnt_q < tx_beats;
      tx_ren  = (state_q == StTxData) & sink_ready & tx_room;
      tx_beat = tx_ren & CHNL_TX_DATA_VALID;
      tmo_hit = tmo_q == TmoLast;
   end

   assign busy               = busy_q;
   assign done               = done_q;
   assign err                = err_q;
   assign tx_len_rcvd        = tx_len_q;
   assign src_ready          = rx_beat;
   assign sink_data          = CHNL_TX_DATA;
   assign sink_valid         = (state_q == StTxData) & tx_room & CHNL_TX_DATA_VALID;
   assign CHNL_RX            = rx_q;
   assign CHNL_RX_LAST       = 1'b1;
   assign CHNL_RX_LEN        = len_q;
   assign CHNL_RX_OFF        = '0;
   assign CHNL_RX_DATA       = src_data;
   assign CHNL_RX_DATA_VALID = (state_q == StRxData) & src_valid;
   assign CHNL_TX_ACK        = tx_ack_q;
   assign CHNL_TX_DATA_REN   = tx_ren;
   assign unused_inputs      = ^{CHNL_TX_LAST, CHNL_TX_OFF};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         len_q    <= '0;
         tx_len_q <= '0;
         cnt_q    <= '0;
         tmo_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rx_q     <= 1'b0;
         tx_ack_q <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         tx_ack_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  len_q   <= len;
                  cnt_q   <= '0;
                  tmo_q   <= '0;
                  busy_q  <= 1'b1;
                  rx_q    <= 1'b1;
                  state_q <= StRxReq;
               end
            end
            StRxReq: begin
               // Progress is checked before saturation so a last-moment ack still wins.
               if (CHNL_RX_ACK) begin
                  tmo_q <= '0;
                  if (len_q == '0) begin
                     rx_q    <= 1'b0;
                     state_q <= StTxWait;
                  end else begin
                     state_q <= StRxData;
                  end
               end else if (tmo_hit) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  rx_q    <= 1'b0;
                  len_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            StRxData: begin
               if (rx_beat) begin
                  tmo_q <= '0;
                  cnt_q <= cnt_q + 33'd1;
                  if (cnt_q + 33'd1 == rx_beats) begin
                     rx_q    <= 1'b0;
                     state_q <= StTxWait;
                  end
               end else if (tmo_hit) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  rx_q    <= 1'b0;
                  len_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            StTxWait: begin
               if (CHNL_TX) begin
                  tmo_q    <= '0;
                  tx_len_q <= CHNL_TX_LEN;
                  tx_ack_q <= 1'b1;
                  state_q  <= StTxAck;
               end else if (tmo_hit) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  len_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            StTxAck: begin
               cnt_q   <= '0;
               tmo_q   <= '0;
               state_q <= (tx_len_q == '0) ? StDone : StTxData;
            end
            StTxData: begin
               if (tx_beat) begin
                  tmo_q <= '0;
                  cnt_q <= cnt_q + 33'd1;
                  if (cnt_q + 33'd1 == tx_beats) state_q <= StDone;
               end else if (tmo_hit) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  len_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            StDone: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_iob_pcie_chnl_host.sv
// Bench for iob_pcie_chnl_host: table of RX/TX transfers against a behavioural user channel,
// plus watchdog and mid-transfer reset sequences.
module tb_iob_pcie_chnl_host;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start;
   logic [31:0] len;
   logic        busy, done, err;
   logic [31:0] tx_len_rcvd;
   logic [63:0] src_data;
   logic        src_valid, src_ready;
   logic [63:0] sink_data;
   logic        sink_valid, sink_ready;
   logic        CHNL_RX, CHNL_RX_ACK, CHNL_RX_LAST;
   logic [31:0] CHNL_RX_LEN;
   logic [30:0] CHNL_RX_OFF;
   logic [63:0] CHNL_RX_DATA;
   logic        CHNL_RX_DATA_VALID, CHNL_RX_DATA_REN;
   logic        CHNL_TX, CHNL_TX_ACK;
   logic [31:0] CHNL_TX_LEN;
   logic [63:0] CHNL_TX_DATA;
   logic        CHNL_TX_DATA_VALID, CHNL_TX_DATA_REN;

   always #5 clk = ~clk;

   iob_pcie_chnl_host #(.C_PCI_DATA_WIDTH(64), .TIMEOUT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done), .err(err),
      .tx_len_rcvd(tx_len_rcvd), .src_data(src_data), .src_valid(src_valid),
      .src_ready(src_ready), .sink_data(sink_data), .sink_valid(sink_valid),
      .sink_ready(sink_ready), .CHNL_RX(CHNL_RX), .CHNL_RX_ACK(CHNL_RX_ACK),
      .CHNL_RX_LAST(CHNL_RX_LAST), .CHNL_RX_LEN(CHNL_RX_LEN), .CHNL_RX_OFF(CHNL_RX_OFF),
      .CHNL_RX_DATA(CHNL_RX_DATA), .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID),
      .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN), .CHNL_TX(CHNL_TX), .CHNL_TX_ACK(CHNL_TX_ACK),
      .CHNL_TX_LAST(1'b1), .CHNL_TX_LEN(CHNL_TX_LEN), .CHNL_TX_OFF(31'd0),
      .CHNL_TX_DATA(CHNL_TX_DATA), .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID),
      .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN)
   );

   typedef struct {
      int len;
      int tx_len;
      bit rnd;
      int exp_rxb;
      int exp_snk;
   } vec_t;

   vec_t vecs[8];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Environment state: source stream, user channel model, sink monitor.
   int          cyc = 0;
   bit          rand_mode, no_ack;
   int          tx_len;
   logic [63:0] src_beats[$];
   logic [63:0] tx_beats[$];
   logic [63:0] sink_got[$];
   logic [31:0] u_rx_words[$];
   int          src_idx, tx_idx, u_phase, u_delay, u_rx_beats, u_beats_exp, idle_run;
   logic [31:0] u_len;
   int          done_cnt, err_cnt, ack_cnt;
   bit          rx_pending;
   logic        rx_after_last, prev_rx, err_busy, err_rx;
   int          rx_rise_cyc, err_cyc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // A stalled handshake is forced through after a few idle cycles to stay inside the watchdog.
   function automatic bit coin();
      if (!rand_mode || idle_run >= 6) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int pick_delay();
      return rand_mode ? int'($urandom_range(0, 3)) : 0;
   endfunction

   task automatic env_reset();
      src_beats.delete();
      tx_beats.delete();
      sink_got.delete();
      u_rx_words.delete();
      src_idx = 0; tx_idx = 0; u_phase = 0; u_delay = pick_delay();
      u_rx_beats = 0; u_beats_exp = 0; idle_run = 0; u_len = '0;
      done_cnt = 0; err_cnt = 0; ack_cnt = 0;
      rx_pending = 0; rx_after_last = 1'b1; prev_rx = 1'b0;
      rx_rise_cyc = -1; err_cyc = -1; err_busy = 1'bx; err_rx = 1'bx;
      no_ack = 0;
   endtask

   always @(negedge clk) begin
      int  ph;
      bit  progress;
      cyc++;
      if (rst) begin
         src_valid = 0; src_data = '0; sink_ready = 0; CHNL_RX_ACK = 0; CHNL_RX_DATA_REN = 0;
         CHNL_TX = 0; CHNL_TX_LEN = '0; CHNL_TX_DATA = '0; CHNL_TX_DATA_VALID = 0;
      end else begin
         src_valid = (src_idx < src_beats.size()) && coin();
         src_data  = src_valid ? src_beats[src_idx] : 64'h0;
         sink_ready = coin();
         CHNL_RX_ACK = 0;
         if (u_phase == 0 && CHNL_RX && !no_ack) begin
            if (u_delay > 0) u_delay--;
            else CHNL_RX_ACK = 1;
         end
         CHNL_RX_DATA_REN = (u_phase == 1) && coin();
         CHNL_TX = (u_phase == 2) && (u_delay == 0);
         if (u_phase == 2 && u_delay > 0) u_delay--;
         CHNL_TX_LEN = 32'(tx_len);
         CHNL_TX_DATA_VALID = (u_phase == 3) && (tx_idx < tx_beats.size()) && coin();
         CHNL_TX_DATA = CHNL_TX_DATA_VALID ? tx_beats[tx_idx] : 64'h0;
         #1;
         progress = 0;
         if (done) done_cnt++;
         if (err && err_cyc < 0) begin
            err_cyc = cyc; err_busy = busy; err_rx = CHNL_RX;
         end
         if (err) err_cnt++;
         if (CHNL_TX_ACK) ack_cnt++;
         if (CHNL_RX && !prev_rx && rx_rise_cyc < 0) rx_rise_cyc = cyc;
         prev_rx = CHNL_RX;
         if (rx_pending) begin
            rx_after_last = CHNL_RX;
            rx_pending = 0;
         end
         if (src_valid && src_ready) src_idx++;
         if (sink_valid && sink_ready) begin
            sink_got.push_back(sink_data);
            progress = 1;
         end
         ph = u_phase;
         case (ph)
            0: if (CHNL_RX_ACK && CHNL_RX) begin
               u_len = CHNL_RX_LEN;
               u_beats_exp = (int'(u_len) + 1) / 2;
               u_phase = (u_beats_exp == 0) ? 2 : 1;
               u_delay = pick_delay();
               progress = 1;
            end
            1: if (CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN) begin
               u_rx_words.push_back(CHNL_RX_DATA[31:0]);
               if (2 * u_rx_beats + 1 < int'(u_len)) u_rx_words.push_back(CHNL_RX_DATA[63:32]);
               u_rx_beats++;
               progress = 1;
               if (u_rx_beats == u_beats_exp) begin
                  u_phase = 2;
                  rx_pending = 1;
               end
            end
            2: if (CHNL_TX_ACK) begin
               u_phase = 3;
               tx_idx = 0;
               progress = 1;
            end
            3: begin
               if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) tx_idx++;
               if (tx_idx == tx_beats.size()) u_phase = 4;
            end
            default: ;
         endcase
         idle_run = progress ? 0 : idle_run + 1;
      end
   end

   task automatic pulse_start(input int n);
      @(posedge clk); #2;
      start = 1; len = 32'(n);
      @(posedge clk); #2;
      start = 0;
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      logic [31:0] w[$];
      logic [31:0] t[$];
      rand_mode = v.rnd;
      env_reset();
      tx_len = v.tx_len;
      for (int i = 0; i < v.len; i++) w.push_back(v.rnd ? $urandom : 32'(i));
      for (int b = 0; b < (v.len + 1) / 2; b++)
         src_beats.push_back({(2 * b + 1 < v.len) ? w[2 * b + 1] : (32'hA5A5_0000 | 32'(b)),
                              w[2 * b]});
      for (int i = 0; i < v.tx_len; i++) t.push_back(i < v.len ? w[i] : $urandom);
      for (int b = 0; b < (v.tx_len + 1) / 2; b++)
         tx_beats.push_back({(2 * b + 1 < v.tx_len) ? t[2 * b + 1] : (32'h5A5A_0000 | 32'(b)),
                             t[2 * b]});
      pulse_start(v.len);
      // A second start while busy must not disturb the latched length.
      @(posedge clk); #2;
      start = 1; len = 32'(v.len + 7);
      @(posedge clk); #2;
      start = 0; len = 32'(v.len);
      chk({tag, " rx_len_hold"}, CHNL_RX_LEN, 64'(v.len));
      for (int k = 0; k < 3000 && done_cnt == 0 && err_cnt == 0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
      chk({tag, " err_pulses"}, 64'(err_cnt), 64'd0);
      chk({tag, " busy_end"}, 64'(busy), 64'd0);
      chk({tag, " rx_len_at_ack"}, 64'(u_len), 64'(v.len));
      chk({tag, " rx_beats"}, 64'(u_rx_beats), 64'(v.exp_rxb));
      chk({tag, " src_used"}, 64'(src_idx), 64'(v.exp_rxb));
      chk({tag, " tx_ack_cycles"}, 64'(ack_cnt), 64'd1);
      chk({tag, " tx_len_rcvd"}, 64'(tx_len_rcvd), 64'(v.tx_len));
      chk({tag, " sink_beats"}, 64'(sink_got.size()), 64'(v.exp_snk));
      if (v.len > 0) chk({tag, " rx_drop_after_last"}, 64'(rx_after_last), 64'd0);
      chk({tag, " rx_words"}, 64'(u_rx_words.size()), 64'(v.len));
      for (int i = 0; i < v.len && i < u_rx_words.size(); i++)
         chk($sformatf("%s rx_word[%0d]", tag, i), 64'(u_rx_words[i]), 64'(w[i]));
      for (int i = 0; i < tx_beats.size() && i < sink_got.size(); i++)
         chk($sformatf("%s sink_beat[%0d]", tag, i), sink_got[i], tx_beats[i]);
   endtask

   initial begin
      vec_t v2;
      vecs[0] = '{4, 4, 1'b0, 2, 2};
      vecs[1] = '{3, 3, 1'b0, 2, 2};
      vecs[2] = '{0, 0, 1'b0, 0, 0};
      vecs[3] = '{7, 5, 1'b1, 4, 3};
      vecs[4] = '{10, 9, 1'b1, 5, 5};
      vecs[5] = '{1, 2, 1'b1, 1, 1};
      vecs[6] = '{16, 16, 1'b1, 8, 8};
      vecs[7] = '{5, 0, 1'b1, 3, 0};
      start = 0; len = '0; tx_len = 0; rand_mode = 0;
      env_reset();
      repeat (3) @(posedge clk);
      #2;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst err", 64'(err), 64'd0);
      chk("rst chnl_rx", 64'(CHNL_RX), 64'd0);
      chk("rst rx_last", 64'(CHNL_RX_LAST), 64'd1);
      chk("rst rx_len", 64'(CHNL_RX_LEN), 64'd0);
      chk("rst tx_len_rcvd", 64'(tx_len_rcvd), 64'd0);
      chk("rst tx_ack", 64'(CHNL_TX_ACK), 64'd0);
      rst = 0;

      for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("v%0d", i));

      // Watchdog: the user never acknowledges the RX request.
      rand_mode = 0;
      env_reset();
      no_ack = 1; tx_len = 0;
      pulse_start(4);
      for (int k = 0; k < 100 && err_cnt == 0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      chk("tmo err_pulses", 64'(err_cnt), 64'd1);
      chk("tmo latency", 64'(err_cyc - rx_rise_cyc), 64'd15);
      chk("tmo busy_at_err", 64'(err_busy), 64'd0);
      chk("tmo rx_at_err", 64'(err_rx), 64'd0);
      chk("tmo done_pulses", 64'(done_cnt), 64'd0);
      chk("tmo rx_after", 64'(CHNL_RX), 64'd0);

      // Reset in the middle of a 4-beat RX transfer.
      rand_mode = 0;
      env_reset();
      tx_len = 8;
      for (int b = 0; b < 4; b++) src_beats.push_back({32'(200 + 2 * b + 1), 32'(200 + 2 * b)});
      pulse_start(8);
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #2;
         if (u_rx_beats >= 1) break;
      end
      chk("mid beats_before_rst", 64'(u_rx_beats), 64'd1);
      rst = 1;
      #1;
      chk("mid busy", 64'(busy), 64'd0);
      chk("mid chnl_rx", 64'(CHNL_RX), 64'd0);
      chk("mid rx_valid", 64'(CHNL_RX_DATA_VALID), 64'd0);
      chk("mid src_ready", 64'(src_ready), 64'd0);
      chk("mid rx_len", 64'(CHNL_RX_LEN), 64'd0);
      chk("mid tx_ack", 64'(CHNL_TX_ACK), 64'd0);
      chk("mid rx_last", 64'(CHNL_RX_LAST), 64'd1);
      env_reset();
      repeat (2) @(posedge clk);
      #2;
      rst = 0;
      repeat (4) @(posedge clk);
      #2;
      chk("mid no_done", 64'(done_cnt), 64'd0);
      chk("mid no_err", 64'(err_cnt), 64'd0);
      v2 = '{2, 2, 1'b0, 1, 1};
      run_txn(v2, "after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
